product_accumulator: RTL

Streaming accumulator directly downstream of the approximate logarithmic multiplier. It accepts the multiplier's signed 16-bit products over a valid/ready handshake and sums each group of VEC_LEN consecutive products into a saturating signed accumulator. Each completed sum, with a sticky overflow flag, goes to a one-entry output buffer. The next vector can accumulate while the previous result waits for the consumer.

---
 rtl/product_accumulator.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Sums each group of VEC_LEN signed 16-bit products into a saturating signed
// accumulator. Each finished sum goes into a one-entry output buffer together
// with a sticky overflow flag. The next vector can accumulate while the
// previous result waits for the consumer.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   clr          synchronous clear of the in-progress vector (buffer untouched)
//   in_valid     in_product is valid
//   in_ready     a product can be accepted this cycle
//   in_product   signed 16-bit product from the multiplier
//   out_valid    out_sum / out_overflow hold a result
//   out_ready    consumer takes the result this cycle
//   out_sum      signed saturated vector sum, ACC_W bits
//   out_overflow saturation happened at least once in that vector
// -----------------------------------------------------------------------------
module product_accumulator #(
    parameter int VEC_LEN = 8,
    parameter int ACC_W   = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [15:0]      in_product,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic                    out_overflow
);

    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    // Saturating add. Bit ACC_W of the result is the saturation flag, the
    // lower ACC_W bits are the clamped sum. Both operands are sign-extended
    // to ACC_W+1 bits, so the true sum always fits; it is out of range
    // exactly when its two top bits disagree, and the top bit then tells
    // which rail was crossed.
    function automatic logic [ACC_W:0] sat_add(
        input logic [ACC_W-1:0] acc,
        input logic [15:0]      prod
    );
        logic [ACC_W:0] ext;
        logic [ACC_W:0] res;
        ext = {acc[ACC_W-1], acc} + {{(ACC_W-15){prod[15]}}, prod};
        if (ext[ACC_W] != ext[ACC_W-1]) begin
            if (ext[ACC_W]) begin
                res = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                res = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            res = {1'b0, ext[ACC_W-1:0]};
        end
        return res;
    endfunction

    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_sum;
    logic             r_out_ovf;

    logic             w_last;
    logic             w_accept;
    logic             w_pop;
    logic [ACC_W:0]   w_add;
    logic [ACC_W-1:0] w_sum;
    logic             w_sat;

    // Handshake decode and the saturating adder.
    always_comb begin
        w_last   = (r_cnt == CNT_W'(VEC_LEN - 1));
        // Only the final product needs buffer space, so only it can stall.
        in_ready = !(w_last && r_out_valid && !out_ready);
        w_accept = in_valid && in_ready && !clr;
        w_pop    = r_out_valid && out_ready;
        w_add    = sat_add(r_acc, in_product);
        w_sum    = w_add[ACC_W-1:0];
        w_sat    = w_add[ACC_W];
    end

    // Accumulator, sticky overflow and product counter for the current vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= {ACC_W{1'b0}};
            r_ovf <= 1'b0;
            r_cnt <= {CNT_W{1'b0}};
        end else if (clr) begin
            r_acc <= {ACC_W{1'b0}};
            r_ovf <= 1'b0;
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            if (w_last) begin
                r_acc <= {ACC_W{1'b0}};
                r_ovf <= 1'b0;
                r_cnt <= {CNT_W{1'b0}};
            end else begin
                r_acc <= w_sum;
                r_ovf <= r_ovf | w_sat;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_acc <= r_acc;
            r_ovf <= r_ovf;
            r_cnt <= r_cnt;
        end
    end

    // One-entry output buffer; a final accept refills it even while popping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= {ACC_W{1'b0}};
            r_out_ovf   <= 1'b0;
        end else if (w_accept && w_last) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_sum;
            r_out_ovf   <= r_ovf | w_sat;
        end else if (w_pop) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= r_out_sum;
            r_out_ovf   <= r_out_ovf;
        end else begin
            r_out_valid <= r_out_valid;
            r_out_sum   <= r_out_sum;
            r_out_ovf   <= r_out_ovf;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_sum      = r_out_sum;
    assign out_overflow = r_out_ovf;

endmodule
